// File: rtl/la5_pkg.sv
// Shared definitions for the LA5 sequencer: FSM states, matrix geometry and
// the row/column to input-register index map.
package la5_pkg;

  localparam int unsigned LA5_N_IN      = 25;
  localparam int unsigned LA5_RES_WORDS = 26;
  localparam int unsigned LA5_ADDR_W    = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_RADDR,
    S_RCAP,
    S_ROUT
  } state_t;

  // Element (r,c), both 1-based, lives at input register 5*(r-1)+(c-1).
  function automatic logic [LA5_ADDR_W-1:0] ld_index(input int unsigned r,
                                                     input int unsigned c);
    return LA5_ADDR_W'(5 * (r - 1) + (c - 1));
  endfunction

endpackage

// File: rtl/la5_rd_stage.sv
// LA5 result read stage: holds the read address, waits out the read latency,
// then presents the captured word on a valid/ready output register.
module la5_rd_stage
  import la5_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = LA5_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              issue_last,
  input  logic [DATA_W-1:0] data_out,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] address,
  output logic              cap,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  logic [LAT_W-1:0] lat;
  logic             armed;
  logic             last_q;

  // Capture fires RD_LAT cycles after the address register took its new value.
  assign cap = armed && (lat == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address   <= '0;
      lat       <= '0;
      armed     <= 1'b0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (issue) begin
        address <= issue_addr;
        last_q  <= issue_last;
        lat     <= LAT_W'(RD_LAT);
        armed   <= 1'b1;
      end else if (armed) begin
        if (cap) armed <= 1'b0;
        else     lat   <= lat - LAT_W'(1);
      end

      if (cap) begin
        out_valid <= 1'b1;
        out_data  <= data_out;
        out_last  <= last_q;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/la5_seq_ctrl.sv
// LA5 sequencer: streams 25 words into LA5, starts it, waits for done (with
// timeout) and streams the 26 result words back out.
module la5_seq_ctrl
  import la5_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_IN      = LA5_N_IN,
  parameter int unsigned RES_WORDS = LA5_RES_WORDS,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned TMO_CYC   = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ld_we,
  output logic [4:0]        ld_idx,
  output logic [DATA_W-1:0] ld_data,
  output logic              la_start,
  input  logic              la_done,
  output logic [4:0]        address,
  input  logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              tmo_err
);

  localparam int unsigned TMR_W = $clog2(TMO_CYC + 1);

  state_t                state, state_n;
  logic [LA5_ADDR_W-1:0] cnt, rd, issue_addr;
  logic [TMR_W-1:0]      tmr;
  logic                  acc, xfer, issue, issue_last, cap, tmo_hit;

  assign acc        = in_valid & in_ready;
  assign xfer       = out_valid & out_ready;
  assign busy       = (state != S_IDLE);
  assign issue_last = (issue_addr == LA5_ADDR_W'(RES_WORDS - 1));

  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    issue_addr = rd;
    tmo_hit    = 1'b0;
    unique case (state)
      S_IDLE:  if (acc) state_n = S_LOAD;
      S_LOAD:  if (acc && cnt == LA5_ADDR_W'(N_IN - 1)) state_n = S_START;
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        if (la_done) begin
          state_n    = S_RADDR;
          issue      = 1'b1;
          issue_addr = '0;
        end else if (tmr == TMR_W'(TMO_CYC - 1)) begin
          state_n = S_IDLE;
          tmo_hit = 1'b1;
        end
      end
      S_RADDR: state_n = S_RCAP;
      S_RCAP:  if (cap) state_n = S_ROUT;
      S_ROUT: begin
        if (xfer) begin
          if (out_last) begin
            state_n = S_IDLE;
          end else begin
            state_n    = S_RADDR;
            issue      = 1'b1;
            issue_addr = rd + LA5_ADDR_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // in_ready is registered from the next state, so it drops the cycle after
  // the last word is taken and is low for the first cycle out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      ld_we    <= 1'b0;
      ld_idx   <= '0;
      ld_data  <= '0;
      la_start <= 1'b0;
      tmo_err  <= 1'b0;
      cnt      <= '0;
      rd       <= '0;
      tmr      <= '0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n == S_IDLE) || (state_n == S_LOAD);
      ld_we    <= acc;
      la_start <= (state == S_START);
      if (acc) begin
        ld_idx  <= cnt;
        ld_data <= in_data;
        cnt     <= (cnt == LA5_ADDR_W'(N_IN - 1)) ? '0 : cnt + LA5_ADDR_W'(1);
      end
      if (tmo_hit)                       tmo_err <= 1'b1;
      else if (acc && state == S_IDLE)   tmo_err <= 1'b0;
      if (state == S_START)              tmr <= '0;
      else if (state == S_WAIT)          tmr <= tmr + TMR_W'(1);
      if (issue)                         rd <= issue_addr;
    end
  end

  la5_rd_stage #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .ADDR_W (LA5_ADDR_W)
  ) u_rd_stage (
    .clk        (clk),
    .reset      (reset),
    .issue      (issue),
    .issue_addr (issue_addr),
    .issue_last (issue_last),
    .data_out   (data_out),
    .out_ready  (out_ready),
    .address    (address),
    .cap        (cap),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last)
  );

endmodule

// File: doc/la5_seq_ctrl.md
Name: la5_seq_ctrl

Overview:
Sequencer for the LA5 5x5 matrix datapath. Accepts 25 input words (row-major, 11..55) on a valid/ready stream and writes them into LA5's input registers, then pulses start and waits for done. It then walks LA5's read `address` port 0..RES_WORDS-1 and returns each `data_out` word on an output valid/ready stream. Sits between the host/bus-side FIFO and LA5; LA5 never sees a host handshake directly.

Parameters:
DATA_W, 32, matrix/result word width
N_IN, 25, input words per matrix (5x5)
RES_WORDS, 26, result words read back (25 elements + 1 scalar at address 25)
RD_LAT, 1, cycles from `address` change to valid `data_out` (1..3)
TMO_CYC, 1023, max cycles waiting for `la_done` before error

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  input word valid
in_data  in  DATA_W  input matrix element
in_ready  out  1  controller accepts input word
ld_we  out  1  write strobe to LA5 input register
ld_idx  out  5  input register index 0..24 (row-major)
ld_data  out  DATA_W  data for LA5 input register
la_start  out  1  one-cycle start pulse to LA5
la_done  in  1  LA5 computation complete (level or pulse)
address  out  5  LA5 result read address
data_out  in  DATA_W  LA5 result word
out_valid  out  1  result word valid
out_data  out  DATA_W  result word
out_last  out  1  marks final result word (index RES_WORDS-1)
out_ready  in  1  consumer accepts result word
busy  out  1  high in any state except IDLE
tmo_err  out  1  sticky timeout flag; cleared by reset or next accepted first input word

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; in_ready, ld_we, la_start, out_valid, out_last, busy=0; ld_idx, address, out_data, ld_data=0; tmo_err=0; counters=0.
- States: IDLE, LOAD, START, WAIT, RADDR, RCAP, ROUT.
- IDLE: in_ready=1. On in_valid&in_ready: ld_we=1 next cycle with ld_idx=0, ld_data=in_data; clear tmo_err; go LOAD with cnt=1.
- LOAD: in_ready=1; each accepted word is registered to ld_we/ld_idx=cnt/ld_data (1-cycle latency, ld_we=0 when no handshake). Gaps in in_valid are allowed. After word cnt=N_IN-1 is accepted, in_ready=0 from the next cycle; go START.
- START: la_start=1 for exactly one cycle (the cycle after the last ld_we); go WAIT; clear the timer.
- WAIT: timer increments each cycle. On la_done=1: go RADDR, rd=0. If the timer reaches TMO_CYC first: set tmo_err, go IDLE with no output words. la_done asserted in any other state is ignored.
- RADDR: drive address=rd; wait RD_LAT cycles (state RCAP counts), then capture out_data<=data_out, out_valid=1, out_last=(rd==RES_WORDS-1); go ROUT.
- ROUT: hold out_valid/out_data/out_last stable until out_ready. On handshake: out_valid=0; if last, go IDLE; else rd++, go RADDR. `address` holds its value until the next RADDR.
- Throughput: RD_LAT+2 cycles per result word minimum. out_ready asserted early has no effect until out_valid.
- in_valid during START/WAIT/read-back: in_ready=0, data is not consumed.
- Reset mid-operation: immediate return to IDLE; any partially loaded matrix is discarded; no la_start is issued.
- Counter widths: 5 bits; no wrap beyond N_IN-1 / RES_WORDS-1.

Decomposition:
- Shared package la5_pkg: state encoding enum, N_IN=25, RES_WORDS=26, address width 5, LA5 index map (row r, col c -> 5*(r-1)+(c-1)).
- One natural sub-module: la5_rd_stage (address issue + RD_LAT delay + output holding register with valid/ready). The controller FSM is the top level.

Test Plan:
- Load 25 words 1..25 back-to-back, LA5 model asserts done 10 cycles after start -> ld_idx 0..24 with matching ld_data, single la_start pulse one cycle after the ld_idx=24 write, 26 results read at address 0..25, out_last only on the 26th word.
- in_valid toggling every other cycle during load -> still exactly 25 ld_we strobes, indices contiguous, no duplicates.
- out_ready low for 5 cycles on word 3 -> out_data/out_valid stable, address holds at 3, no skipped or repeated words.
- la_done never asserted -> tmo_err=1 after 1023 WAIT cycles, state IDLE, out_valid never rises; next input word clears tmo_err.
- Reset asserted after 12 words loaded -> all outputs at reset values within the same cycle; a fresh 25-word load then runs a normal full sequence.
- RD_LAT=3 with an LA5 model returning address*7 -> out_data = 0,7,14..175 in order.
